// File: rtl/tl_ul_a_credit_queue.sv
// TileLink-UL A-channel request FIFO that only issues downstream while the
// number of outstanding (A accepted, D not yet returned) requests is below a limit.
module tl_ul_a_credit_queue #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned AW           = 9,
  parameter int unsigned SZW          = 2,
  parameter int unsigned SRCW         = 1,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [2:0]               enq_opcode,
  input  logic [2:0]               enq_param,
  input  logic [SZW-1:0]           enq_size,
  input  logic [SRCW-1:0]          enq_source,
  input  logic [AW-1:0]            enq_address,
  input  logic [DW/8-1:0]          enq_mask,
  input  logic [DW-1:0]            enq_data,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [2:0]               deq_opcode,
  output logic [2:0]               deq_param,
  output logic [SZW-1:0]           deq_size,
  output logic [SRCW-1:0]          deq_source,
  output logic [AW-1:0]            deq_address,
  output logic [DW/8-1:0]          deq_mask,
  output logic [DW-1:0]            deq_data,
  input  logic                     d_fire,
  output logic [$clog2(DEPTH):0]   count,
  output logic [3:0]               inflight,
  output logic                     underflow_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned MW = DW / 8;

  typedef struct packed {
    logic [2:0]      opcode;
    logic [2:0]      param;
    logic [SZW-1:0]  size;
    logic [SRCW-1:0] source;
    logic [AW-1:0]   address;
    logic [MW-1:0]   mask;
    logic [DW-1:0]   data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        enq_entry;
  entry_t        head_entry;
  logic [PW:0]   wptr_q, wptr_d;
  logic [PW:0]   rptr_q, rptr_d;
  logic [3:0]    inflight_q, inflight_d;
  logic          err_q, err_d;
  logic          full, empty, enq_fire, deq_fire;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    full      = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    empty     = (wptr_q == rptr_q);
    enq_ready = !full;
    deq_valid = !empty && (inflight_q < 4'(MAX_INFLIGHT));
    enq_fire  = enq_valid && enq_ready;
    deq_fire  = deq_valid && deq_ready;
  end

  always_comb begin
    enq_entry = '{opcode: enq_opcode, param: enq_param, size: enq_size, source: enq_source,
                  address: enq_address, mask: enq_mask, data: enq_data};
    head_entry  = mem_q[rptr_q[PW-1:0]];
    deq_opcode  = head_entry.opcode;
    deq_param   = head_entry.param;
    deq_size    = head_entry.size;
    deq_source  = head_entry.source;
    deq_address = head_entry.address;
    deq_mask    = head_entry.mask;
    deq_data    = head_entry.data;
  end

  // Next-state for pointers, credit counter and the sticky underflow flag.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    if (enq_fire) wptr_d = wptr_q + (PW+1)'(1);
    if (deq_fire) rptr_d = rptr_q + (PW+1)'(1);
    if (deq_fire && !d_fire) begin
      inflight_d = inflight_q + 4'd1;
    end else if (d_fire && !deq_fire) begin
      if (inflight_q == 4'd0) err_d = 1'b1;
      else                    inflight_d = inflight_q - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // Payload storage is intentionally left unreset.
  always_ff @(posedge clock) begin
    if (enq_fire) mem_q[wptr_q[PW-1:0]] <= enq_entry;
  end

  assign count         = wptr_q - rptr_q;
  assign inflight      = inflight_q;
  assign underflow_err = err_q;

endmodule

// File: tb/tb_tl_ul_a_credit_queue.sv
// Bench for tl_ul_a_credit_queue: directed scenarios plus a random run against
// a queue-based reference model of the credit-limited FIFO.
module tb_tl_ul_a_credit_queue;

  localparam int unsigned DEPTH        = 2;
  localparam int unsigned AW           = 9;
  localparam int unsigned SZW          = 2;
  localparam int unsigned SRCW         = 1;
  localparam int unsigned DW           = 32;
  localparam int unsigned MAX_INFLIGHT = 2;

  typedef struct packed {
    logic [2:0]      opcode;
    logic [2:0]      param;
    logic [SZW-1:0]  size;
    logic [SRCW-1:0] source;
    logic [AW-1:0]   address;
    logic [DW/8-1:0] mask;
    logic [DW-1:0]   data;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enq_valid = 1'b0, deq_ready = 1'b0, d_fire = 1'b0;
  logic enq_ready, deq_valid, underflow_err;
  logic [2:0] enq_opcode = '0, enq_param = '0, deq_opcode, deq_param;
  logic [SZW-1:0] enq_size = '0, deq_size;
  logic [SRCW-1:0] enq_source = '0, deq_source;
  logic [AW-1:0] enq_address = '0, deq_address;
  logic [DW/8-1:0] enq_mask = '0, deq_mask;
  logic [DW-1:0] enq_data = '0, deq_data;
  logic [$clog2(DEPTH):0] count;
  logic [3:0] inflight;

  int checks = 0;
  int failures = 0;

  // Reference model: pending requests, outstanding credits, sticky error.
  ent_t q_m[$];
  int   infl_m = 0;
  bit   err_m = 1'b0;

  always #5 clock = ~clock;

  tl_ul_a_credit_queue #(
    .DEPTH(DEPTH), .AW(AW), .SZW(SZW), .SRCW(SRCW), .DW(DW), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_opcode(enq_opcode), .enq_param(enq_param), .enq_size(enq_size),
    .enq_source(enq_source), .enq_address(enq_address), .enq_mask(enq_mask),
    .enq_data(enq_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_opcode(deq_opcode), .deq_param(deq_param), .deq_size(deq_size),
    .deq_source(deq_source), .deq_address(deq_address), .deq_mask(deq_mask),
    .deq_data(deq_data),
    .d_fire(d_fire), .count(count), .inflight(inflight), .underflow_err(underflow_err)
  );

  function automatic ent_t dut_head();
    ent_t e;
    e = '{opcode: deq_opcode, param: deq_param, size: deq_size, source: deq_source,
          address: deq_address, mask: deq_mask, data: deq_data};
    return e;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e = '{opcode: 3'($urandom), param: 3'($urandom), size: SZW'($urandom),
          source: SRCW'($urandom), address: AW'($urandom), mask: (DW/8)'($urandom),
          data: DW'($urandom)};
    return e;
  endfunction

  task automatic set_enq(input ent_t e);
    enq_opcode  = e.opcode;
    enq_param   = e.param;
    enq_size    = e.size;
    enq_source  = e.source;
    enq_address = e.address;
    enq_mask    = e.mask;
    enq_data    = e.data;
  endtask

  // One clock: model applies the handshake rules to the inputs held this cycle.
  task automatic step();
    bit   m_enq_rdy, m_deq_vld, m_enq_f, m_deq_f, m_d;
    ent_t e;
    m_enq_rdy = q_m.size() < DEPTH;
    m_deq_vld = (q_m.size() != 0) && (infl_m < int'(MAX_INFLIGHT));
    m_enq_f   = enq_valid && m_enq_rdy;
    m_deq_f   = m_deq_vld && deq_ready;
    m_d       = d_fire;
    e = '{opcode: enq_opcode, param: enq_param, size: enq_size, source: enq_source,
          address: enq_address, mask: enq_mask, data: enq_data};
    @(posedge clock);
    if (m_deq_f) void'(q_m.pop_front());
    if (m_enq_f) q_m.push_back(e);
    if (m_deq_f && !m_d) infl_m++;
    else if (m_d && !m_deq_f) begin
      if (infl_m == 0) err_m = 1'b1;
      else infl_m--;
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enq_valid = 1'b0; deq_ready = 1'b0; d_fire = 1'b0;
    q_m.delete(); infl_m = 0; err_m = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({deq_valid, count, inflight, underflow_err} !== 8'h00) begin
      failures++;
      $display("FAIL reset_state got dv=%b cnt=%0d infl=%0d err=%b exp all 0",
               deq_valid, count, inflight, underflow_err);
    end
    do_reset();
    #1;
    checks++;
    if (enq_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_enq_ready got=%b exp=1", enq_ready);
    end
  endtask

  task automatic test_single();
    ent_t e;
    do_reset();
    e = '{opcode: 3'd4, param: 3'd0, size: 2'd2, source: 1'b1, address: 9'h1A4,
          mask: 4'hF, data: 32'h0};
    set_enq(e); enq_valid = 1'b1; deq_ready = 1'b1;
    #1;
    checks++;
    if (deq_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_no_flowthrough got dv=%b exp=0", deq_valid);
    end
    step();
    enq_valid = 1'b0;
    #1;
    checks++;
    if (deq_valid !== 1'b1 || dut_head() !== e || inflight !== 4'd0) begin
      failures++;
      $display("FAIL single_issue got dv=%b head=%h infl=%0d exp dv=1 head=%h infl=0",
               deq_valid, dut_head(), inflight, e);
    end
    step();
    #1;
    checks++;
    if (inflight !== 4'd1 || deq_valid !== 1'b0 || count !== 2'd0) begin
      failures++;
      $display("FAIL single_credit got infl=%0d dv=%b cnt=%0d exp infl=1 dv=0 cnt=0",
               inflight, deq_valid, count);
    end
  endtask

  task automatic test_credit();
    ent_t a[3];
    do_reset();
    deq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a[i] = rand_ent();
      set_enq(a[i]); enq_valid = 1'b1;
      step();
    end
    enq_valid = 1'b0;
    #1;
    checks++;
    if (deq_valid !== 1'b0 || count !== 2'd1 || inflight !== 4'd2) begin
      failures++;
      $display("FAIL credit_hold got dv=%b cnt=%0d infl=%0d exp dv=0 cnt=1 infl=2",
               deq_valid, count, inflight);
    end
    d_fire = 1'b1;
    step();
    d_fire = 1'b0;
    #1;
    checks++;
    if (deq_valid !== 1'b1 || dut_head() !== a[2] || inflight !== 4'd1) begin
      failures++;
      $display("FAIL credit_release got dv=%b head=%h infl=%0d exp dv=1 head=%h infl=1",
               deq_valid, dut_head(), inflight, a[2]);
    end
    step();
    #1;
    checks++;
    if (inflight !== 4'd2 || count !== 2'd0) begin
      failures++;
      $display("FAIL credit_reissue got infl=%0d cnt=%0d exp infl=2 cnt=0", inflight, count);
    end
  endtask

  task automatic test_full();
    ent_t e[3];
    do_reset();
    for (int i = 0; i < 3; i++) e[i] = rand_ent();
    for (int i = 0; i < 2; i++) begin
      set_enq(e[i]); enq_valid = 1'b1;
      step();
    end
    #1;
    checks++;
    if (count !== 2'd2 || enq_ready !== 1'b0 || deq_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_state got cnt=%0d er=%b dv=%b exp cnt=2 er=0 dv=1",
               count, enq_ready, deq_valid);
    end
    set_enq(e[2]); enq_valid = 1'b1; deq_ready = 1'b1;
    step();
    enq_valid = 1'b0; deq_ready = 1'b0;
    #1;
    checks++;
    if (count !== 2'd1 || dut_head() !== e[1] || enq_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_no_bypass got cnt=%0d head=%h er=%b exp cnt=1 head=%h er=1",
               count, dut_head(), enq_ready, e[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] base;
    ent_t          e;
    do_reset();
    deq_ready = 1'b1;
    base = AW'($urandom);
    e = rand_ent();
    for (int cyc = 0; cyc < 22; cyc++) begin
      enq_valid = (cyc < 20);
      e.address = base + AW'(cyc);
      set_enq(e);
      d_fire = (infl_m > 0);
      #1;
      if (cyc >= 1 && cyc <= 20) begin
        checks++;
        if (deq_valid !== 1'b1 || deq_address !== base + AW'(cyc - 1) || count !== 2'd1) begin
          failures++;
          $display("FAIL b2b_order cyc=%0d got dv=%b addr=%h cnt=%0d exp dv=1 addr=%h cnt=1",
                   cyc, deq_valid, deq_address, count, base + AW'(cyc - 1));
        end
      end
      step();
    end
    d_fire = 1'b0;
    #1;
    checks++;
    if (underflow_err !== 1'b0 || count !== 2'd0) begin
      failures++;
      $display("FAIL b2b_end got err=%b cnt=%0d exp err=0 cnt=0", underflow_err, count);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    d_fire = 1'b1;
    #1;
    checks++;
    if (underflow_err !== 1'b0) begin
      failures++;
      $display("FAIL underflow_early got=%b exp=0", underflow_err);
    end
    step();
    d_fire = 1'b0;
    #1;
    checks++;
    if (underflow_err !== 1'b1 || inflight !== 4'd0) begin
      failures++;
      $display("FAIL underflow_set got err=%b infl=%0d exp err=1 infl=0", underflow_err, inflight);
    end
    step(); step();
    #1;
    checks++;
    if (underflow_err !== 1'b1) begin
      failures++;
      $display("FAIL underflow_sticky got=%b exp=1", underflow_err);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (underflow_err !== 1'b0) begin
      failures++;
      $display("FAIL underflow_async_clear got=%b exp=0", underflow_err);
    end
    do_reset();
  endtask

  task automatic test_same_cycle();
    do_reset();
    deq_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_enq(rand_ent()); enq_valid = 1'b1;
      step();
    end
    enq_valid = 1'b0;
    d_fire = 1'b1;
    #1;
    checks++;
    if (inflight !== 4'd1 || deq_valid !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_pre got infl=%0d dv=%b exp infl=1 dv=1", inflight, deq_valid);
    end
    step();
    d_fire = 1'b0;
    #1;
    checks++;
    if (inflight !== 4'd1 || underflow_err !== 1'b0 || count !== 2'd0) begin
      failures++;
      $display("FAIL same_cycle got infl=%0d err=%b cnt=%0d exp infl=1 err=0 cnt=0",
               inflight, underflow_err, count);
    end
  endtask

  task automatic test_random();
    bit m_dv;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      enq_valid = ($urandom_range(3) != 0);
      deq_ready = ($urandom_range(3) != 0);
      d_fire    = (infl_m > 0) ? ($urandom_range(2) == 0) : ($urandom_range(31) == 0);
      set_enq(rand_ent());
      #1;
      m_dv = (q_m.size() != 0) && (infl_m < int'(MAX_INFLIGHT));
      checks++;
      if (enq_ready !== (q_m.size() < DEPTH) || deq_valid !== m_dv ||
          count !== 2'(q_m.size()) || inflight !== 4'(infl_m) || underflow_err !== err_m ||
          (m_dv && dut_head() !== q_m[0])) begin
        failures++;
        $display("FAIL random cyc=%0d got er=%b dv=%b cnt=%0d infl=%0d err=%b exp er=%b dv=%b cnt=%0d infl=%0d err=%b",
                 cyc, enq_ready, deq_valid, count, inflight, underflow_err,
                 q_m.size() < DEPTH, m_dv, q_m.size(), infl_m, err_m);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_credit();
    test_full();
    test_back_to_back();
    test_underflow();
    test_same_cycle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
